// File: rtl/lsu_cluster.sv
// Shared load-store unit: per-lane request slots, round-robin arbitration onto one read and one write port.
// Optional address bounds check enabled by defining LSU_BOUNDS_CHECK_EN.
module lsu_cluster #(
  parameter int NUM_THREADS        = 4,
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int DATA_MEM_LIMIT     = 256
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_THREADS-1:0]                   load_enable,
  input  logic [NUM_THREADS-1:0]                   store_enable,
  input  logic [NUM_THREADS*DATA_MEM_ADDR_BITS-1:0] address,
  input  logic [NUM_THREADS*DATA_MEM_DATA_BITS-1:0] store_data,
  output logic [NUM_THREADS*DATA_MEM_DATA_BITS-1:0] load_data,
  output logic [NUM_THREADS-1:0]                   lsu_busy,
  output logic [NUM_THREADS-1:0]                   lsu_done,
  output logic [NUM_THREADS-1:0]                   lsu_error,
  output logic                                     data_mem_read_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]            data_mem_read_address,
  input  logic                                     data_mem_read_ready,
  input  logic [DATA_MEM_DATA_BITS-1:0]            data_mem_read_data,
  output logic                                     data_mem_write_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]            data_mem_write_address,
  output logic [DATA_MEM_DATA_BITS-1:0]            data_mem_write_data,
  input  logic                                     data_mem_write_ready
);

  localparam int A     = DATA_MEM_ADDR_BITS;
  localparam int D     = DATA_MEM_DATA_BITS;
  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_READ  = 2'd1;
  localparam logic [1:0] P_WRITE = 2'd2;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [NUM_THREADS-1:0] r_slot_vld;
  logic [NUM_THREADS-1:0] r_slot_ld;
  logic [A-1:0]           r_slot_addr [NUM_THREADS];
  logic [D-1:0]           r_slot_data [NUM_THREADS];

  logic [1:0]             r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_lane;
  logic                   r_rvalid;
  logic                   r_wvalid;
  logic [A-1:0]           r_maddr;
  logic [D-1:0]           r_mwdata;
  logic [NUM_THREADS*D-1:0] r_load_data;
  logic [NUM_THREADS-1:0] r_done;
  logic [NUM_THREADS-1:0] r_error;

  logic                   w_any;
  logic [PTR_W-1:0]       w_grant;
  logic                   w_fault;

  function automatic logic [PTR_W-1:0] lane_at(input logic [PTR_W-1:0] base, input int ofs);
    int sum;
    sum = (int'(base) + ofs) % NUM_THREADS;
    return sum[PTR_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic [A-1:0] a);
    return 64'(a) >= 64'(DATA_MEM_LIMIT);
  endfunction

  // Scan downward so the lane closest to the pointer is the one left selected
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (r_slot_vld[lane_at(r_ptr, i)]) begin
        w_any   = 1'b1;
        w_grant = lane_at(r_ptr, i);
      end
    end
  end

  assign w_fault = BOUNDS_EN && out_of_range(r_slot_addr[w_grant]);

  always_ff @(posedge clk) begin
    r_done  <= '0;
    r_error <= '0;
    if (reset) begin
      r_slot_vld  <= '0;
      r_slot_ld   <= '0;
      r_state     <= P_IDLE;
      r_ptr       <= '0;
      r_lane      <= '0;
      r_rvalid    <= 1'b0;
      r_wvalid    <= 1'b0;
      r_maddr     <= '0;
      r_mwdata    <= '0;
      r_load_data <= '0;
    end else begin
      // A lane whose done pulse is showing ignores its enables for that cycle
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (!r_slot_vld[t] && !r_done[t] && (load_enable[t] || store_enable[t])) begin
          r_slot_vld[t]  <= 1'b1;
          r_slot_ld[t]   <= load_enable[t];
          r_slot_addr[t] <= address[t*A +: A];
          r_slot_data[t] <= store_data[t*D +: D];
        end
      end

      case (r_state)
        P_IDLE: begin
          if (w_any) begin
            if (w_fault) begin
              r_slot_vld[w_grant] <= 1'b0;
              r_done[w_grant]     <= 1'b1;
              r_error[w_grant]    <= 1'b1;
              if (r_slot_ld[w_grant]) begin
                r_load_data[w_grant*D +: D] <= '0;
              end
              r_ptr <= lane_at(w_grant, 1);
            end else begin
              r_lane   <= w_grant;
              r_maddr  <= r_slot_addr[w_grant];
              r_mwdata <= r_slot_data[w_grant];
              if (r_slot_ld[w_grant]) begin
                r_rvalid <= 1'b1;
                r_state  <= P_READ;
              end else begin
                r_wvalid <= 1'b1;
                r_state  <= P_WRITE;
              end
            end
          end
        end
        P_READ: begin
          if (data_mem_read_ready) begin
            r_load_data[r_lane*D +: D] <= data_mem_read_data;
            r_rvalid           <= 1'b0;
            r_done[r_lane]     <= 1'b1;
            r_slot_vld[r_lane] <= 1'b0;
            r_ptr              <= lane_at(r_lane, 1);
            r_state            <= P_IDLE;
          end
        end
        P_WRITE: begin
          if (data_mem_write_ready) begin
            r_wvalid           <= 1'b0;
            r_done[r_lane]     <= 1'b1;
            r_slot_vld[r_lane] <= 1'b0;
            r_ptr              <= lane_at(r_lane, 1);
            r_state            <= P_IDLE;
          end
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  assign load_data              = r_load_data;
  assign lsu_busy               = r_slot_vld;
  assign lsu_done               = r_done;
  assign lsu_error              = r_error;
  assign data_mem_read_valid    = r_rvalid;
  assign data_mem_read_address  = r_maddr;
  assign data_mem_write_valid   = r_wvalid;
  assign data_mem_write_address = r_maddr;
  assign data_mem_write_data    = r_mwdata;

endmodule

// File: tb/tb_lsu_cluster.sv
// Directed bench for lsu_cluster: vector table of single-lane transactions plus contention,
// round-robin wrap, idle-ready, mid-transaction reset and address bounds sequences.
module tb_lsu_cluster;
  localparam int NT = 4;
  localparam int AB = 8;
  localparam int DB = 8;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam int LIMIT = 128;
`else
  localparam int LIMIT = 256;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NT-1:0]     load_enable;
  logic [NT-1:0]     store_enable;
  logic [NT*AB-1:0]  address;
  logic [NT*DB-1:0]  store_data;
  logic [NT*DB-1:0]  load_data;
  logic [NT-1:0]     lsu_busy;
  logic [NT-1:0]     lsu_done;
  logic [NT-1:0]     lsu_error;
  logic              data_mem_read_valid;
  logic [AB-1:0]     data_mem_read_address;
  logic              data_mem_read_ready;
  logic [DB-1:0]     data_mem_read_data;
  logic              data_mem_write_valid;
  logic [AB-1:0]     data_mem_write_address;
  logic [DB-1:0]     data_mem_write_data;
  logic              data_mem_write_ready;

  // Memory model controls: automatic responder or manually held ready levels
  logic          auto_mem;
  int            mem_lat;
  logic          a_rready, a_wready, m_rready, m_wready;
  logic [DB-1:0] a_rdata;
  int            rd_wait, wr_wait;

  int            nvec, nerr;
  logic [AB-1:0] rd_log [64];
  logic [AB-1:0] wa_log [64];
  logic [DB-1:0] wd_log [64];
  int            rd_cnt, wr_cnt;
  int            ov_cnt, md_cnt, er_cnt;

  always #5 clk = ~clk;

  assign data_mem_read_ready  = auto_mem ? a_rready : m_rready;
  assign data_mem_write_ready = auto_mem ? a_wready : m_wready;
  assign data_mem_read_data   = a_rdata;

  lsu_cluster #(
    .NUM_THREADS(NT), .DATA_MEM_ADDR_BITS(AB), .DATA_MEM_DATA_BITS(DB), .DATA_MEM_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .load_enable(load_enable), .store_enable(store_enable),
    .address(address), .store_data(store_data),
    .load_data(load_data), .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_error(lsu_error),
    .data_mem_read_valid(data_mem_read_valid), .data_mem_read_address(data_mem_read_address),
    .data_mem_read_ready(data_mem_read_ready), .data_mem_read_data(data_mem_read_data),
    .data_mem_write_valid(data_mem_write_valid), .data_mem_write_address(data_mem_write_address),
    .data_mem_write_data(data_mem_write_data), .data_mem_write_ready(data_mem_write_ready)
  );

  // Memory returns address ^ 0x4A after mem_lat idle cycles of valid
  always @(negedge clk) begin
    if (data_mem_read_valid) begin
      if (rd_wait >= mem_lat) begin
        a_rready <= 1'b1;
        a_rdata  <= data_mem_read_address ^ 8'h4A;
      end else begin
        a_rready <= 1'b0;
        rd_wait  <= rd_wait + 1;
      end
    end else begin
      a_rready <= 1'b0;
      rd_wait  <= 0;
    end
    if (data_mem_write_valid) begin
      if (wr_wait >= mem_lat) a_wready <= 1'b1;
      else begin
        a_wready <= 1'b0;
        wr_wait  <= wr_wait + 1;
      end
    end else begin
      a_wready <= 1'b0;
      wr_wait  <= 0;
    end
  end

  initial begin
    a_rready = 1'b0; a_wready = 1'b0; a_rdata = '0;
    rd_wait = 0; wr_wait = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (data_mem_read_valid && data_mem_read_ready) begin
        rd_log[rd_cnt & 63] <= data_mem_read_address;
        rd_cnt <= rd_cnt + 1;
      end
      if (data_mem_write_valid && data_mem_write_ready) begin
        wa_log[wr_cnt & 63] <= data_mem_write_address;
        wd_log[wr_cnt & 63] <= data_mem_write_data;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  initial begin
    ov_cnt = 0; md_cnt = 0; er_cnt = 0;
  end

  always @(negedge clk) begin
    if (data_mem_read_valid && data_mem_write_valid) ov_cnt <= ov_cnt + 1;
    if ($countones(lsu_done) > 1) md_cnt <= md_cnt + 1;
`ifndef LSU_BOUNDS_CHECK_EN
    if (lsu_error != '0) er_cnt <= er_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         lane;
    logic       ld;
    logic       st;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic       exp_rd;
    logic [7:0] exp_ld;
  } vec_t;

  // One isolated transaction, starting and ending on a falling edge with the DUT idle
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bit seen;
    mem_lat = v.lat;
    load_enable  = '0;
    store_enable = '0;
    load_enable[v.lane]  = v.ld;
    store_enable[v.lane] = v.st;
    address[v.lane*AB +: AB]    = v.addr;
    store_data[v.lane*DB +: DB] = v.wdata;
    @(negedge clk);
    load_enable  = '0;
    store_enable = '0;
    check({tag, "_busy"}, 32'(lsu_busy[v.lane]), 32'd1);
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_mem_read_valid || data_mem_write_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin
      check({tag, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_rd_valid"}, 32'(data_mem_read_valid), 32'(v.exp_rd));
    check({tag, "_wr_valid"}, 32'(data_mem_write_valid), 32'(!v.exp_rd));
    if (v.exp_rd) begin
      check({tag, "_rd_addr"}, 32'(data_mem_read_address), 32'(v.addr));
    end else begin
      check({tag, "_wr_addr"}, 32'(data_mem_write_address), 32'(v.addr));
      check({tag, "_wr_data"}, 32'(data_mem_write_data), 32'(v.wdata));
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (lsu_done != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_done"}, 32'(lsu_done), 32'(1 << v.lane));
    check({tag, "_error"}, 32'(lsu_error), 32'd0);
    check({tag, "_load_data"}, 32'(load_data[v.lane*DB +: DB]), 32'(v.exp_ld));
    check({tag, "_latency"}, 32'(cyc), 32'(2 + v.lat));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(lsu_done), 32'd0);
    check({tag, "_busy_clr"}, 32'(lsu_busy[v.lane]), 32'd0);
  endtask

  vec_t       vt [6];
  vec_t       v;
  int         base, rbase, first_lane;
  int         dcnt [NT];
  logic [7:0] cdat [NT];
  bit         seen, rv;

  initial begin
    //        lane ld    st    addr   wdata  lat rd    exp load_data
    vt[0] = '{2, 1'b1, 1'b0, 8'h10, 8'h00, 0, 1'b1, 8'h5A};
    vt[1] = '{0, 1'b0, 1'b1, 8'h33, 8'hC3, 1, 1'b0, 8'h00};
    vt[2] = '{1, 1'b1, 1'b1, 8'h20, 8'hEE, 2, 1'b1, 8'h6A};
    vt[3] = '{3, 1'b1, 1'b0, 8'h7F, 8'h00, 0, 1'b1, 8'h35};
    vt[4] = '{2, 1'b0, 1'b1, 8'h7F, 8'h99, 0, 1'b0, 8'h5A};
    vt[5] = '{0, 1'b1, 1'b0, 8'h00, 8'h00, 1, 1'b1, 8'h4A};
    cdat[0] = 8'h11; cdat[1] = 8'h22; cdat[2] = 8'h33; cdat[3] = 8'h44;

    nvec = 0; nerr = 0;
    auto_mem = 1'b1; mem_lat = 0; m_rready = 1'b0; m_wready = 1'b0;
    reset = 1'b1;
    load_enable = '0; store_enable = '0; address = '0; store_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(lsu_busy), 32'd0);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_error", 32'(lsu_error), 32'd0);
    check("rst_rvalid", 32'(data_mem_read_valid), 32'd0);
    check("rst_wvalid", 32'(data_mem_write_valid), 32'd0);
    check("rst_load_data", 32'(load_data), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Ready held high while nothing is outstanding
    auto_mem = 1'b0; m_rready = 1'b1; m_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready_no_done", 32'(lsu_done), 32'd0);
    end
    m_rready = 1'b0; m_wready = 1'b0;

    // Reset while a read waits for ready
    load_enable[1] = 1'b1;
    address[1*AB +: AB] = 8'h22;
    @(negedge clk);
    load_enable = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_mem_read_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_valid_seen", 32'(seen), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_rvalid", 32'(data_mem_read_valid), 32'd0);
    check("rst_mid_busy", 32'(lsu_busy), 32'd0);
    check("rst_mid_done", 32'(lsu_done), 32'd0);
    @(negedge clk);
    check("rst_mid_no_done", 32'(lsu_done), 32'd0);
    auto_mem = 1'b1;
    v = '{3, 1'b1, 1'b0, 8'h33, 8'h00, 0, 1'b1, 8'h79};
    run_vec(v, "post_rst");

    // All four lanes store together; pointer is 0 here
    base = wr_cnt;
    mem_lat = 0;
    for (int i = 0; i < NT; i++) begin
      store_enable[i] = 1'b1;
      address[i*AB +: AB] = 8'h40 + 8'(i);
      store_data[i*DB +: DB] = cdat[i];
      dcnt[i] = 0;
    end
    @(negedge clk);
    store_enable = '0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NT; i++) if (lsu_done[i]) dcnt[i]++;
      @(negedge clk);
    end
    check("cont_writes", 32'(wr_cnt - base), 32'd4);
    for (int i = 0; i < NT; i++) begin
      check($sformatf("cont_addr%0d", i), 32'(wa_log[(base + i) & 63]), 32'(8'h40 + 8'(i)));
      check($sformatf("cont_data%0d", i), 32'(wd_log[(base + i) & 63]), 32'(cdat[i]));
      check($sformatf("cont_done%0d", i), 32'(dcnt[i]), 32'd1);
    end

    // Lane 2 load leaves the pointer at 3, then lanes 0 and 3 compete
    v = '{2, 1'b1, 1'b0, 8'h12, 8'h00, 0, 1'b1, 8'h58};
    run_vec(v, "pre_wrap");
    rbase = rd_cnt;
    first_lane = -1;
    load_enable = 4'b1001;
    address[0*AB +: AB] = 8'h50;
    address[3*AB +: AB] = 8'h53;
    @(negedge clk);
    load_enable = '0;
    for (int c = 0; c < 20; c++) begin
      if (first_lane < 0) begin
        for (int i = 0; i < NT; i++) if (lsu_done[i]) first_lane = i;
      end
      @(negedge clk);
    end
    check("wrap_reads", 32'(rd_cnt - rbase), 32'd2);
    check("wrap_first_addr", 32'(rd_log[rbase & 63]), 32'h53);
    check("wrap_second_addr", 32'(rd_log[(rbase + 1) & 63]), 32'h50);
    check("wrap_first_done", 32'(first_lane), 32'd3);
    check("wrap_ld3", 32'(load_data[3*DB +: DB]), 32'h19);
    check("wrap_ld0", 32'(load_data[0*DB +: DB]), 32'h1A);

    // Address bounds: lane 1 first gets a nonzero value, then loads from 0x90
    v = '{1, 1'b1, 1'b0, 8'h20, 8'h00, 0, 1'b1, 8'h6A};
    run_vec(v, "pre_bnd");
`ifdef LSU_BOUNDS_CHECK_EN
    load_enable[1] = 1'b1;
    address[1*AB +: AB] = 8'h90;
    @(negedge clk);
    load_enable = '0;
    seen = 1'b0;
    rv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (data_mem_read_valid || data_mem_write_valid) rv = 1'b1;
      if (lsu_done != '0 && !seen) begin
        seen = 1'b1;
        check("bnd_done", 32'(lsu_done), 32'h2);
        check("bnd_error", 32'(lsu_error), 32'h2);
        check("bnd_load_data", 32'(load_data[1*DB +: DB]), 32'h0);
      end
      @(negedge clk);
    end
    check("bnd_done_seen", 32'(seen), 32'd1);
    check("bnd_no_issue", 32'(rv), 32'd0);
`else
    v = '{1, 1'b1, 1'b0, 8'h90, 8'h00, 0, 1'b1, 8'hDA};
    run_vec(v, "hi_addr");
`endif
    base = wr_cnt;
    v = '{2, 1'b0, 1'b1, 8'h7F, 8'h99, 0, 1'b0, 8'h58};
    run_vec(v, "edge_store");
    check("edge_store_written", 32'(wr_cnt - base), 32'd1);

    check("no_rw_overlap", 32'(ov_cnt), 32'd0);
    check("no_multi_done", 32'(md_cnt), 32'd0);
    check("no_stray_error", 32'(er_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu_cluster.md
Name: lsu_cluster

Overview:
- Parametrised multi-thread load-store unit. It serves NUM_THREADS thread lanes of one compute core over a single shared data-memory channel.
- Each lane issues one LDR or STR at a time. Lanes are latched into per-lane request slots and arbitrated round-robin onto one valid/ready read port and one valid/ready write port.
- Completion is reported per lane with a one-cycle done pulse.
- Sits between the core's per-thread register files and the data memory controller, replacing per-thread LSU instances.

Parameters:
- NUM_THREADS, 4, number of thread lanes (1..16)
- DATA_MEM_ADDR_BITS, 8, memory address width
- DATA_MEM_DATA_BITS, 8, memory data width
- DATA_MEM_LIMIT, 256, first illegal address; used only with LSU_BOUNDS_CHECK_EN

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- load_enable  input  NUM_THREADS  per-lane LDR request, bit t = lane t
- store_enable  input  NUM_THREADS  per-lane STR request
- address  input  NUM_THREADS*DATA_MEM_ADDR_BITS  per-lane address from Rs; lane t in slice [t*A +: A]
- store_data  input  NUM_THREADS*DATA_MEM_DATA_BITS  per-lane store data from Rt
- load_data  output  NUM_THREADS*DATA_MEM_DATA_BITS  per-lane loaded data for Rd
- lsu_busy  output  NUM_THREADS  lane has a request in flight
- lsu_done  output  NUM_THREADS  one-cycle completion pulse per lane
- lsu_error  output  NUM_THREADS  one-cycle pulse with done on a bounds fault
- data_mem_read_valid  output  1  read request
- data_mem_read_address  output  DATA_MEM_ADDR_BITS  read address
- data_mem_read_ready  input  1  read data valid / accept
- data_mem_read_data  input  DATA_MEM_DATA_BITS  read data
- data_mem_write_valid  output  1  write request
- data_mem_write_address  output  DATA_MEM_ADDR_BITS  write address
- data_mem_write_data  output  DATA_MEM_DATA_BITS  write data
- data_mem_write_ready  input  1  write accepted

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, named reset.
- Reset values: all outputs 0; all slots empty; round-robin pointer = 0; port FSM = P_IDLE. Reset mid-transaction abandons it; valid drops the cycle after the reset edge. No done pulse is generated for abandoned requests.
- Lane capture:
  - At an edge where lane t is not busy and load_enable[t]|store_enable[t]=1, the slot latches op, address and store_data, and lsu_busy[t] goes 1.
  - If both enables are high, load wins.
  - Enables while busy are ignored.
  - Enables in the same cycle as that lane's done pulse are ignored; the lane is free from the next cycle.
- Port FSM states:
  - P_IDLE: if any slot is pending and not granted, select the first pending lane scanning from pointer upward with wrap-around. Assert read_valid or write_valid with that lane's address/data at the next edge. Move to P_READ or P_WRITE.
  - P_READ: hold valid, address and data stable until data_mem_read_ready=1 is sampled. At that edge:
    - load_data[t] <= read_data
    - valid <= 0
    - lsu_done[t] <= 1 for exactly one cycle
    - lsu_busy[t] <= 0
    - pointer <= t+1 mod NUM_THREADS
    - return to P_IDLE
  - P_WRITE: same handshake using write_ready; load_data is unchanged.
- Ready inputs sampled while the matching valid is low are ignored.
- Read and write valid are never high together.
- Latency with no contention: enable at edge E, valid high after edge E+1, done high after the edge where ready is sampled. Minimum 3 cycles from enable to done.
- Arbitration is fair: each pending lane waits at most NUM_THREADS-1 transactions.
- load_data[t] holds its value until the next load by lane t completes.
- Multiple lsu_done bits are never high in the same cycle.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- When defined, a granted slot whose address >= DATA_MEM_LIMIT is not issued to memory. In P_IDLE it completes directly at the grant edge:
  - lsu_done[t] and lsu_error[t] pulse together for one cycle
  - load_data[t] <= 0 on a faulting load
  - no write occurs
  - pointer advances normally
- When undefined, all addresses are issued and lsu_error is constant 0.

Test Plan:
- Single lane: NUM_THREADS=4, lane 2 LDR addr 0x10, memory returns 0x5A with ready one cycle after valid -> read_address=0x10, load_data lane 2=0x5A, lsu_done=4'b0100 for one cycle, 3-4 cycles after enable.
- Contention: lanes 0-3 all STR in the same cycle, data 0x11/0x22/0x33/0x44 -> writes issued in lane order 0,1,2,3; one done pulse each; write_valid never overlaps read_valid.
- Round-robin wrap: pointer at 3; lanes 0 and 3 pending -> lane 3 served first, then lane 0.
- Both enables high on lane 1 -> read issued, no write; ready held high while idle -> no spurious done.
- Reset asserted while read_valid is high awaiting ready -> next cycle all valid, busy and done are 0; a fresh request then completes normally.
- LSU_BOUNDS_CHECK_EN, DATA_MEM_LIMIT=128: LDR at 0x90 -> no read_valid; done and error pulse together; load_data=0. STR at 0x7F -> normal write, error stays 0.
